// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Receives 8N1-style UART frames from i_rx. The baud clock comes in as a
// 16x-oversampling tick, i_tick, supplied by the baud-rate tick generator.
// Each frame is shifted in LSB first. When the frame completes, the parallel
// word is presented together with a one-clock done pulse and a framing-error
// flag.
//
// Parameters
//   NB_DATA      data bits per frame (>= 2), LSB first
//   SB_TICK      oversampling ticks spent in the stop bit (16 = one stop bit)
//
// Ports
//   clk          system clock
//   i_rst_n      synchronous active-low reset
//   i_tick       baud x16 tick, one clock wide (consecutive ticks are legal)
//   i_rx         serial line, idle high
//   o_data       last received word (held until the next completed frame)
//   o_rx_done    one-clock pulse; o_data / o_frame_err valid
//   o_frame_err  stop bit was sampled low on the last frame
//
// Build option
//   UART_RX_SYNC_EN  when defined, i_rx passes through a two-flop synchroniser
//                    (both flops reset high). Every observation of the line is
//                    then two clocks later. When undefined, i_rx must already
//                    be synchronous to clk.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err
);

  localparam int                NB_IDX      = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [NB_IDX-1:0] N_LAST      = NB_IDX'(NB_DATA - 1);
  localparam logic [3:0]        S_START_MID = 4'd7;
  localparam logic [3:0]        S_BIT_LAST  = 4'd15;
  localparam logic [3:0]        S_STOP_LAST = 4'(SB_TICK - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [3:0]           s_r, s_nxt_s;
  logic [NB_IDX-1:0]    n_r, n_nxt_s;
  logic [NB_DATA-1:0]   b_r, b_nxt_s;
  logic [NB_DATA-1:0]   data_r, data_nxt_s;
  logic                 rx_done_r, rx_done_nxt_s;
  logic                 frame_err_r, frame_err_nxt_s;
  logic                 rx_s;

`ifdef UART_RX_SYNC_EN
  logic rx_meta_r;
  logic rx_sync_r;

  // Two-flop synchroniser; resets to the idle (high) line level so that
  // reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= i_rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  assign rx_s = rx_sync_r;
`else
  assign rx_s = i_rx;
`endif

  // State register: FSM state, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      s_r         <= 4'd0;
      n_r         <= '0;
      b_r         <= '0;
      data_r      <= '0;
      rx_done_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      s_r         <= s_nxt_s;
      n_r         <= n_nxt_s;
      b_r         <= b_nxt_s;
      data_r      <= data_nxt_s;
      rx_done_r   <= rx_done_nxt_s;
      frame_err_r <= frame_err_nxt_s;
    end
  end

  // Next-state logic: start detection is untimed; everything else advances
  // only on clocks carrying a tick.
  always_comb begin
    state_nxt_s = state_r;
    s_nxt_s     = s_r;
    n_nxt_s     = n_r;
    b_nxt_s     = b_r;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt_s = ST_START;
          s_nxt_s     = 4'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (i_tick) begin
          if (s_r == S_START_MID) begin
            // Mid start bit: a line that has gone high again was a glitch.
            if (!rx_s) begin
              state_nxt_s = ST_DATA;
              s_nxt_s     = 4'd0;
              n_nxt_s     = '0;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            s_nxt_s = s_r + 4'd1;
          end
        end else begin
          s_nxt_s = s_r;
        end
      end
      ST_DATA: begin
        if (i_tick) begin
          if (s_r == S_BIT_LAST) begin
            s_nxt_s = 4'd0;
            b_nxt_s = {rx_s, b_r[NB_DATA-1:1]};
            if (n_r == N_LAST) begin
              state_nxt_s = ST_STOP;
            end else begin
              n_nxt_s = n_r + {{(NB_IDX-1){1'b0}}, 1'b1};
            end
          end else begin
            s_nxt_s = s_r + 4'd1;
          end
        end else begin
          s_nxt_s = s_r;
        end
      end
      ST_STOP: begin
        if (i_tick) begin
          if (s_r == S_STOP_LAST) begin
            state_nxt_s = ST_IDLE;
          end else begin
            s_nxt_s = s_r + 4'd1;
          end
        end else begin
          s_nxt_s = s_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        s_nxt_s     = 4'd0;
        n_nxt_s     = '0;
      end
    endcase
  end

  // Output logic: the edge that consumes the last stop tick delivers the
  // word, the stop-bit check and the done pulse together. A framing error
  // still delivers data.
  always_comb begin
    data_nxt_s      = data_r;
    frame_err_nxt_s = frame_err_r;
    rx_done_nxt_s   = 1'b0;
    if ((state_r == ST_STOP) && i_tick && (s_r == S_STOP_LAST)) begin
      data_nxt_s      = b_r;
      frame_err_nxt_s = ~rx_s;
      rx_done_nxt_s   = 1'b1;
    end else begin
      rx_done_nxt_s   = 1'b0;
    end
  end

  assign o_data      = data_r;
  assign o_rx_done   = rx_done_r;
  assign o_frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Directed frames are driven on i_rx. Each frame pushes its expected word and
// framing flag into a queue. A monitor pops an entry on every o_rx_done and
// compares the outputs against it. The bench also checks the reset state, the
// glitch and abort cases, and the end-to-end latency, with ticks on every
// clock.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_tick;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;

`ifdef UART_RX_SYNC_EN
  localparam int EXP_LAT = 155;
`else
  localparam int EXP_LAT = 153;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   tick_div  = 4;
  int   start_cyc = 0;
  int   done_cnt  = 0;
  bit   lat_en    = 1'b0;

  uart_rx #(.NB_DATA(8), .SB_TICK(16)) dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_tick      (i_tick),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_rx_done   (o_rx_done),
    .o_frame_err (o_frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Clock counter
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Tick generator: one-clock tick every tick_div clocks
  initial begin
    i_tick = 1'b0;
    forever begin
      @(negedge clk);
      i_tick = ((cyc % tick_div) == 0);
    end
  end

  // Monitor: pop and compare on every done pulse
  initial begin
    exp_t e;
    bit   prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_rx_done === 1'b1) begin
        done_cnt++;
        chk("done_width", {31'd0, prev_done}, 32'd0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=data %0h required=no pulse", o_data);
        end else begin
          e = sb_q.pop_front();
          chk("data", {24'd0, o_data}, {24'd0, e.data});
          chk("frame_err", {31'd0, o_frame_err}, {31'd0, e.ferr});
        end
        if (lat_en) begin
          chk("latency", cyc - start_cyc, EXP_LAT);
        end
      end
      prev_done = (o_rx_done === 1'b1);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    i_rx = v;
    repeat (16 * tick_div) @(negedge clk);
  endtask

  // A low stop bit is released after 10 ticks (past its sample point), so the
  // retriggered start detect sees a high line and is rejected.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    exp_t e;
    e.data = d;
    e.ferr = ~stop_bit;
    sb_q.push_back(e);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (stop_bit) begin
      drive_bit(1'b1);
    end else begin
      i_rx = 1'b0;
      repeat (10 * tick_div) @(negedge clk);
      i_rx = 1'b1;
      repeat (6 * tick_div) @(negedge clk);
    end
    i_rx = 1'b1;
  endtask

  initial begin
    i_rx    = 1'b1;
    i_rst_n = 1'b0;
    idle(4);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_done", {31'd0, o_rx_done}, 32'd0);
    chk("rst_ferr", {31'd0, o_frame_err}, 32'd0);
    i_rst_n = 1'b1;
    idle(20);

    // Basic frame, tick every 4 clocks
    send_frame(8'hA5, 1'b1);
    idle(128);
    chk("cnt_a5", done_cnt, 1);

    // Low glitch of 3 ticks
    i_rx = 1'b0;
    idle(12);
    i_rx = 1'b1;
    idle(200);
    chk("glitch_cnt", done_cnt, 1);
    chk("glitch_data", {24'd0, o_data}, 32'hA5);

    // Framing error, then a clean frame
    send_frame(8'h3C, 1'b0);
    idle(128);
    send_frame(8'h81, 1'b1);
    idle(128);
    chk("cnt_ferr", done_cnt, 3);

    // Reset after 3 data bits of 0xFF
    i_rx = 1'b0;
    idle(64);
    i_rx = 1'b1;
    idle(192);
    i_rst_n = 1'b0;
    idle(1);
    i_rst_n = 1'b1;
    chk("abort_data", {24'd0, o_data}, 32'd0);
    chk("abort_done", {31'd0, o_rx_done}, 32'd0);
    chk("abort_ferr", {31'd0, o_frame_err}, 32'd0);
    idle(640);
    chk("abort_cnt", done_cnt, 3);
    send_frame(8'h5A, 1'b1);
    idle(128);
    chk("cnt_5a", done_cnt, 4);

    // Back-to-back frames
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(128);
    chk("cnt_b2b", done_cnt, 6);

    // Latency with a tick on every clock
    tick_div = 1;
    idle(40);
    lat_en = 1'b1;
    send_frame(8'hA5, 1'b1);
    idle(40);
    lat_en = 1'b0;
    chk("cnt_lat", done_cnt, 7);
    chk("queue_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
